mem_arbiter: RTL

- Single-port memory arbiter and sequencer for the rv32 core.
- Shares one external memory bus between the instruction-fetch path (feeds the decoder) and the load/store path.
- Serialises requests and holds the pipeline via `busy` while a transfer is in flight.
- Data accesses have priority over fetches. A timeout guards against a hung bus.

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one external bus between instruction
// fetch and load/store, data first, with a per-access timeout abort.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_strobe,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strobe,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic        busy,
    output logic        bus_err
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
    logic              r_bus_ren,    w_bus_ren_nxt;
    logic              r_bus_wen,    w_bus_wen_nxt;
    logic [31:0]       r_bus_addr,   w_bus_addr_nxt;
    logic [31:0]       r_bus_wdata,  w_bus_wdata_nxt;
    logic [3:0]        r_bus_strobe, w_bus_strobe_nxt;
    logic              r_i_ready,    w_i_ready_nxt;
    logic              r_d_ready,    w_d_ready_nxt;
    logic [31:0]       r_i_rdata,    w_i_rdata_nxt;
    logic [31:0]       r_d_rdata,    w_d_rdata_nxt;
    logic              r_busy,       w_busy_nxt;
    logic              r_bus_err,    w_bus_err_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic; access ends on bus idle or timeout
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bus_ren_nxt    = r_bus_ren;
        w_bus_wen_nxt    = r_bus_wen;
        w_bus_addr_nxt   = r_bus_addr;
        w_bus_wdata_nxt  = r_bus_wdata;
        w_bus_strobe_nxt = r_bus_strobe;
        w_i_ready_nxt    = 1'b0;
        w_d_ready_nxt    = 1'b0;
        w_i_rdata_nxt    = r_i_rdata;
        w_d_rdata_nxt    = r_d_rdata;
        w_bus_err_nxt    = r_bus_err;

        case (r_state)
            S_IDLE: begin
                if (d_ren || d_wen) begin
                    w_state_nxt      = S_DATA;
                    w_cnt_nxt        = '0;
                    w_bus_ren_nxt    = ~d_wen;
                    w_bus_wen_nxt    = d_wen;
                    w_bus_addr_nxt   = d_addr;
                    w_bus_wdata_nxt  = d_wdata;
                    w_bus_strobe_nxt = d_strobe;
                end else if (i_req) begin
                    w_state_nxt      = S_FETCH;
                    w_cnt_nxt        = '0;
                    w_bus_ren_nxt    = 1'b1;
                    w_bus_wen_nxt    = 1'b0;
                    w_bus_addr_nxt   = i_addr;
                    w_bus_wdata_nxt  = '0;
                    w_bus_strobe_nxt = 4'hF;
                end
            end
            S_FETCH, S_DATA: begin
                if (!bus_busy || (r_cnt == CNT_LAST)) begin
                    w_state_nxt   = S_IDLE;
                    w_bus_ren_nxt = 1'b0;
                    w_bus_wen_nxt = 1'b0;
                    if (r_state == S_FETCH) begin
                        w_i_ready_nxt = 1'b1;
                        w_i_rdata_nxt = bus_busy ? ERR_WORD : bus_rdata;
                    end else begin
                        w_d_ready_nxt = 1'b1;
                        if (bus_busy) begin
                            w_d_rdata_nxt = ERR_WORD;
                        end else if (!r_bus_wen) begin
                            w_d_rdata_nxt = bus_rdata;
                        end
                    end
                    if (bus_busy) begin
                        w_bus_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_bus_ren_nxt = 1'b0;
                w_bus_wen_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_bus_ren    <= 1'b0;
            r_bus_wen    <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_strobe <= '0;
            r_i_ready    <= 1'b0;
            r_d_ready    <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_busy       <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_bus_ren    <= w_bus_ren_nxt;
            r_bus_wen    <= w_bus_wen_nxt;
            r_bus_addr   <= w_bus_addr_nxt;
            r_bus_wdata  <= w_bus_wdata_nxt;
            r_bus_strobe <= w_bus_strobe_nxt;
            r_i_ready    <= w_i_ready_nxt;
            r_d_ready    <= w_d_ready_nxt;
            r_i_rdata    <= w_i_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_busy       <= w_busy_nxt;
            r_bus_err    <= w_bus_err_nxt;
        end
    end

    assign i_ready    = r_i_ready;
    assign i_rdata    = r_i_rdata;
    assign d_ready    = r_d_ready;
    assign d_rdata    = r_d_rdata;
    assign bus_ren    = r_bus_ren;
    assign bus_wen    = r_bus_wen;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_strobe = r_bus_strobe;
    assign busy       = r_busy;
    assign bus_err    = r_bus_err;

endmodule
